// File: rtl/io_uart_tx_fifo_if.sv
// Memory-mapped IO bus for the UART transmitter: register select,
// write/read strobes and registered read data.
interface io_uart_tx_fifo_if;
  logic        sel;
  logic [2:0]  io_wordaddr;
  logic [31:0] mem_wdata;
  logic        mem_wstrb;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;

  modport master (
    output sel, io_wordaddr, mem_wdata, mem_wstrb, mem_rstrb,
    input  mem_rdata
  );

  modport slave (
    input  sel, io_wordaddr, mem_wdata, mem_wstrb, mem_rstrb,
    output mem_rdata
  );
endinterface

// File: rtl/io_uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a byte FIFO, with STATUS and
// programmable divisor registers on a one-hot IO word address.
module io_uart_tx_fifo #(
  parameter int CLK_FREQ_HZ = 615000,
  parameter int BAUD_RATE   = 56000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic               clk,
  input  logic               RESET,
  io_uart_tx_fifo_if.slave   bus,
  output logic               TXD,
  output logic               irq
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ_HZ / BAUD_RATE);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, ovf_set;
  logic          wr_data, wr_status, wr_div, rd_any;

  state_t        state;
  logic [15:0]   baud_cnt, div_lat, div_reg;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          nempty_q, bit_done, ovf, busy;
  logic [31:0]   status_word;

  assign wr_data   = bus.sel & bus.mem_wstrb & bus.io_wordaddr[0];
  assign wr_status = bus.sel & bus.mem_wstrb & bus.io_wordaddr[1];
  assign wr_div    = bus.sel & bus.mem_wstrb & bus.io_wordaddr[2];
  assign rd_any    = bus.sel & bus.mem_rstrb & (|bus.io_wordaddr);

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = wr_data & ~full;
  assign ovf_set  = wr_data & full;
  assign bit_done = (baud_cnt == '0);
  // Leaving IDLE uses the one-cycle-old non-empty flag so the start bit
  // lands two clocks after the write; STOP chains on the live count so
  // back-to-back frames stay contiguous.
  assign pop      = ((state == IDLE) & nempty_q) |
                    ((state == STOP) & bit_done & ~empty);

  assign busy        = (state != IDLE) | ~empty;
  assign irq         = (state == IDLE) & empty;
  assign status_word = {{(16-CW){1'b0}}, count, 6'b0, full, 6'b0, ovf, empty, busy};

  // FIFO storage, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.mem_wdata[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Shifter FSM with registered TXD
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      div_lat  <= DIV_RST;
      TXD      <= 1'b1;
      nempty_q <= 1'b0;
    end else begin
      nempty_q <= ~empty;
      case (state)
        IDLE: begin
          if (nempty_q) begin
            state    <= START;
            shreg    <= mem[rd_ptr];
            div_lat  <= div_reg;
            baud_cnt <= div_reg - 16'd1;
            TXD      <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state    <= DATA;
            baud_cnt <= div_lat - 16'd1;
            bit_idx  <= '0;
            TXD      <= shreg[0];
            shreg    <= shreg >> 1;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= div_lat - 16'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              TXD   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TXD     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (!empty) begin
              state    <= START;
              shreg    <= mem[rd_ptr];
              div_lat  <= div_reg;
              baud_cnt <= div_reg - 16'd1;
              TXD      <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow, divisor register and registered read data
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      ovf           <= 1'b0;
      div_reg       <= DIV_RST;
      bus.mem_rdata <= '0;
    end else begin
      if (ovf_set)                             ovf <= 1'b1;
      else if (wr_status && bus.mem_wdata[2])  ovf <= 1'b0;
      if (wr_div) begin
        if (bus.mem_wdata[15:0] < 16'd2) div_reg <= 16'd2;
        else                             div_reg <= bus.mem_wdata[15:0];
      end
      if (rd_any) begin
        if (bus.io_wordaddr[1])      bus.mem_rdata <= status_word;
        else if (bus.io_wordaddr[2]) bus.mem_rdata <= {16'b0, div_reg};
        else                         bus.mem_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_io_uart_tx_fifo.sv
// Directed bench for io_uart_tx_fifo: a scoreboard of expected frames
// (byte and bit period) is filled as bytes are written and drained by a
// TXD monitor that checks every clock of every frame.
module tb_io_uart_tx_fifo;

  localparam logic [2:0] A_DATA = 3'b001;
  localparam logic [2:0] A_STAT = 3'b010;
  localparam logic [2:0] A_DIV  = 3'b100;

  logic clk = 1'b0;
  logic RESET;
  logic TXD, irq;

  io_uart_tx_fifo_if bus ();

  io_uart_tx_fifo #(
    .CLK_FREQ_HZ (1000),
    .BAUD_RATE   (250),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus),
    .TXD   (TXD),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned div;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   frames_seen = 0;
  logic mon_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input int unsigned div);
    exp_t e;
    e.data = d;
    e.div  = div;
    sb.push_back(e);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.io_wordaddr = a; bus.mem_wdata = d; bus.mem_wstrb = 1'b1;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.io_wordaddr = '0; bus.mem_wstrb = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
    bus.sel = 1'b1; bus.io_wordaddr = a; bus.mem_rstrb = 1'b1;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.io_wordaddr = '0; bus.mem_rstrb = 1'b0;
    v = bus.mem_rdata;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 2000; n++) begin
      if (irq === 1'b1 && !mon_busy && sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk(tag, {30'b0, irq, mon_busy}, 32'h2);
  endtask

  // TXD monitor: every clock of a frame is compared with the expected level
  exp_t        m_e;
  logic        m_ok, m_ab, m_lvl, m_exp;
  logic [7:0]  m_got;
  always begin
    @(negedge clk);
    if (!RESET && TXD === 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_frame", 32'(sb.size()), 32'd1);
        for (int n = 0; n < 2000 && TXD === 1'b0; n++) @(negedge clk);
      end else begin
        m_e = sb.pop_front();
        mon_busy = 1'b1; m_ok = 1'b1; m_ab = 1'b0; m_got = '0;
        for (int k = 0; k < 10 && !m_ab; k++) begin
          for (int j = 0; j < int'(m_e.div) && !m_ab; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (RESET) m_ab = 1'b1;
            else begin
              m_lvl = TXD;
              if (k == 0)      m_exp = 1'b0;
              else if (k == 9) m_exp = 1'b1;
              else             m_exp = m_e.data[k-1];
              if (m_lvl !== m_exp) m_ok = 1'b0;
              if (k >= 1 && k <= 8 && j == 0) m_got[k-1] = m_lvl;
            end
          end
        end
        if (!m_ab) begin
          frames_seen++;
          chk("frame", 32'({m_ok, m_got}), 32'({1'b1, m_e.data}));
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int n, f0;
    RESET = 1'b1;
    bus.sel = 1'b0; bus.io_wordaddr = '0; bus.mem_wdata = '0;
    bus.mem_wstrb = 1'b0; bus.mem_rstrb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", 32'(TXD), 32'd1);
    chk("reset_irq", 32'(irq), 32'd1);
    chk("reset_rdata", bus.mem_rdata, 32'h0);
    RESET = 1'b0;

    bus_read(A_STAT, v); chk("status_after_reset", v, 32'h0000_0002);
    bus_read(A_DIV, v);  chk("div_after_reset", v, 32'h0000_0004);
    @(posedge clk); #1;
    chk("rdata_hold", bus.mem_rdata, 32'h0000_0004);
    bus_read(A_DATA, v); chk("data_read_zero", v, 32'h0);

    // single frame 0x55 with start-bit latency and frame length
    f0 = frames_seen;
    expect_frame(8'h55, 4);
    bus_write(A_DATA, 32'h55);
    chk("txd_e0", 32'(TXD), 32'd1);
    chk("irq_low_queued", 32'(irq), 32'd0);
    @(posedge clk); #1; chk("txd_e1", 32'(TXD), 32'd1);
    @(posedge clk); #1; chk("txd_e2_start", 32'(TXD), 32'd0);
    n = 2;
    while (irq !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("frame_len_to_irq", 32'(n), 32'd42);
    wait_idle("idle_0x55");
    chk("frames_0x55", 32'(frames_seen - f0), 32'd1);

    // five back-to-back writes fill the FIFO
    f0 = frames_seen;
    for (int i = 0; i < 5; i++) begin
      expect_frame(8'(8'h11 * (i + 1)), 4);
      bus_write(A_DATA, 32'(8'h11 * (i + 1)));
    end
    bus_read(A_STAT, v); chk("status_full", v, 32'h0004_0201);
    repeat (50) @(posedge clk);
    #1;
    bus_read(A_STAT, v); chk("status_full_cleared", v, 32'h0003_0001);
    wait_idle("idle_5");
    chk("frames_5", 32'(frames_seen - f0), 32'd5);
    bus_read(A_STAT, v); chk("status_idle_5", v, 32'h0000_0002);

    // six writes: last dropped, OVF sticky until cleared
    f0 = frames_seen;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) expect_frame(8'(8'hA0 + i), 4);
      bus_write(A_DATA, 32'(8'hA0 + i));
    end
    bus_read(A_STAT, v); chk("status_ovf", v, 32'h0004_0205);
    bus_write(A_STAT, 32'h4);
    bus_read(A_STAT, v); chk("status_ovf_clr", v, 32'h0004_0201);
    wait_idle("idle_6");
    chk("frames_6", 32'(frames_seen - f0), 32'd5);

    // divisor clamp and mid-frame change
    bus_write(A_DIV, 32'h1);
    bus_read(A_DIV, v); chk("div_clamp", v, 32'h0000_0002);
    bus_write(A_DIV, 32'h4);
    f0 = frames_seen;
    expect_frame(8'hA5, 4);
    expect_frame(8'h3C, 8);
    bus_write(A_DATA, 32'hA5);
    bus_write(A_DATA, 32'h3C);
    repeat (10) @(posedge clk);
    #1;
    bus_write(A_DIV, 32'h8);
    bus_read(A_DIV, v); chk("div_8", v, 32'h0000_0008);
    wait_idle("idle_div");
    chk("frames_div", 32'(frames_seen - f0), 32'd2);

    // reset during data bit 3 of a queued sequence
    bus_write(A_DIV, 32'h6);
    f0 = frames_seen;
    expect_frame(8'h0F, 6);
    bus_write(A_DATA, 32'h0F);
    bus_write(A_DATA, 32'hF0);
    bus_write(A_DATA, 32'hAA);
    repeat (26) @(posedge clk);
    #1;
    RESET = 1'b1;
    sb.delete();
    #1;
    chk("midreset_txd", 32'(TXD), 32'd1);
    chk("midreset_irq", 32'(irq), 32'd1);
    chk("midreset_rdata", bus.mem_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
    bus_read(A_STAT, v); chk("postreset_status", v, 32'h0000_0002);
    bus_read(A_DIV, v);  chk("postreset_div", v, 32'h0000_0004);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (TXD !== 1'b1) n++;
    end
    chk("postreset_line_idle", 32'(n), 32'd0);
    chk("postreset_frames", 32'(frames_seen - f0), 32'd0);

    // write with sel low has no effect
    bus.sel = 1'b0; bus.io_wordaddr = A_DATA; bus.mem_wdata = 32'h99; bus.mem_wstrb = 1'b1;
    @(posedge clk); #1;
    bus.io_wordaddr = '0; bus.mem_wstrb = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus_read(A_STAT, v); chk("sel_low_ignored", v, 32'h0000_0002);

    // STATUS read in the same cycle as a DATA push sees the pre-edge count
    f0 = frames_seen;
    expect_frame(8'h73, 4);
    bus.sel = 1'b1; bus.io_wordaddr = A_DATA | A_STAT; bus.mem_wdata = 32'h73;
    bus.mem_wstrb = 1'b1; bus.mem_rstrb = 1'b1;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.io_wordaddr = '0; bus.mem_wstrb = 1'b0; bus.mem_rstrb = 1'b0;
    chk("push_read_pre_edge", bus.mem_rdata, 32'h0000_0002);
    bus_read(A_STAT, v); chk("push_read_next", v, 32'h0001_0001);
    wait_idle("idle_pushread");
    chk("frames_pushread", 32'(frames_seen - f0), 32'd1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
